// File: rtl/delay_sched.sv
// delay_sched -- shared delay-timer scheduler.
//
// Several control FSMs each need a timed wait. Instead of giving each one its
// own delay counter, they share one cycle counter. Waiting requesters are
// served one at a time in round-robin order. A delay longer than N_MAX is
// rejected: done and err pulse together and no grant is issued.
//
// Optional feature (compile-time macro DELAY_SCHED_WDOG_EN):
//   If the granted requester drops req while its delay runs, the run is
//   cancelled. The block returns to IDLE and pulses abort for one cycle.
//   When the macro is undefined, the run completes normally and abort is
//   tied to 0.
//
// Parameters:
//   NREQ   number of requesters (2..8)
//   CBITS  width of the counter and of each length field
//   N_MAX  largest accepted delay length (must fit in CBITS)
//
// Ports:
//   clk    rising-edge clock
//   rst    synchronous active-high reset
//   req    per-requester request level, held until that requester's done
//   len    per-requester length, slice i = len[i*CBITS +: CBITS], sampled at grant
//   gnt    one-hot grant, high for len+1 cycles while the delay runs
//   done   one-hot, one-cycle completion pulse
//   err    pulses with done when the request was rejected (len > N_MAX)
//   abort  one-cycle pulse when a run is cancelled by the watchdog
//   busy   high whenever the scheduler is not IDLE
//   cnt    current timer value
module delay_sched #(
    parameter int NREQ  = 4,
    parameter int CBITS = 14,
    parameter int N_MAX = 10000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*CBITS-1:0] len,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       done,
    output logic                  err,
    output logic                  abort,
    output logic                  busy,
    output logic [CBITS-1:0]      cnt
);

    localparam int              IW     = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [IW-1:0]   LAST   = IW'(NREQ - 1);
    localparam logic [CBITS-1:0] NMAX_C = CBITS'(N_MAX);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [IW-1:0]       ptr_q,   ptr_d;    // round-robin start point
    logic [IW-1:0]       idx_q,   idx_d;    // requester being served
    logic [CBITS-1:0]    len_q,   len_d;    // length latched at grant
    logic [CBITS-1:0]    cnt_q,   cnt_d;
    logic [NREQ-1:0]     gnt_q,   gnt_d;
    logic [NREQ-1:0]     done_q,  done_d;
    logic                err_q,   err_d;
    logic                busy_q,  busy_d;
`ifdef DELAY_SCHED_WDOG_EN
    logic                abort_q, abort_d;
`endif

    logic                found;
    logic [IW-1:0]       sel;
    logic [CBITS-1:0]    sel_len;
    logic [IW-1:0]       ptr_after;

    function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] i);
        logic [NREQ-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // First set request at or after the pointer, wrapping modulo NREQ.
    always_comb begin
        found = 1'b0;
        sel   = ptr_q;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && req[(int'(ptr_q) + k) % NREQ]) begin
                found = 1'b1;
                sel   = IW'((int'(ptr_q) + k) % NREQ);
            end
        end
    end

    assign sel_len   = len[int'(sel)*CBITS +: CBITS];
    // The pointer moves past whoever was just served (completed, rejected or
    // aborted), so a requester that keeps req high cannot starve the others.
    assign ptr_after = (idx_q == LAST) ? '0 : idx_q + IW'(1);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        err_d   = 1'b0;
`ifdef DELAY_SCHED_WDOG_EN
        abort_d = 1'b0;
`endif

        case (state_q)
            S_IDLE: begin
                if (found) begin
                    idx_d = sel;
                    len_d = sel_len;
                    cnt_d = '0;
                    if (sel_len <= NMAX_C) begin
                        state_d = S_RUN;
                        gnt_d   = onehot(sel);
                    end else begin
                        // Rejected: complete at once and never grant.
                        state_d = S_DONE;
                        done_d  = onehot(sel);
                        err_d   = 1'b1;
                    end
                end
            end

            S_RUN: begin
`ifdef DELAY_SCHED_WDOG_EN
                if (!req[idx_q]) begin
                    state_d = S_IDLE;
                    gnt_d   = '0;
                    cnt_d   = '0;
                    abort_d = 1'b1;
                    ptr_d   = ptr_after;
                end else
`endif
                if (cnt_q == len_q) begin
                    // Stop at len, so the counter can never wrap.
                    state_d = S_DONE;
                    gnt_d   = '0;
                    done_d  = onehot(idx_q);
                end else begin
                    cnt_d = cnt_q + CBITS'(1);
                end
            end

            S_DONE: begin
                ptr_d   = ptr_after;
                cnt_d   = '0;
                state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase

        // busy is registered from the next state so it lines up with state_q.
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
`ifdef DELAY_SCHED_WDOG_EN
            abort_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
`ifdef DELAY_SCHED_WDOG_EN
            abort_q <= abort_d;
`endif
        end
    end

    assign gnt  = gnt_q;
    assign done = done_q;
    assign err  = err_q;
    assign busy = busy_q;
    assign cnt  = cnt_q;
`ifdef DELAY_SCHED_WDOG_EN
    assign abort = abort_q;
`else
    assign abort = 1'b0;
`endif

endmodule
